// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle FSM sequencer for the mips datapath
// Control outputs decode from the current state (plus opcode/zero/mem_ready where needed).
module multicycle_control #(
  parameter int MAX_WAIT = 16
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       ula_zero_flag,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [1:0] PCSource,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] RegDst,
  output logic       MemtoReg,
  output logic       isJAL,
  output logic       RegWrite,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ula_operation,
  output logic       bus_err,
  output logic [3:0] state
);
  localparam int CW = $clog2(MAX_WAIT + 1);

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  typedef enum logic [3:0] {
    FETCH     = 4'd0,
    DECODE    = 4'd1,
    R_EXEC    = 4'd2,
    R_WB      = 4'd3,
    I_EXEC    = 4'd4,
    I_WB      = 4'd5,
    MEM_ADDR  = 4'd6,
    MEM_READ  = 4'd7,
    MEM_WB    = 4'd8,
    MEM_WRITE = 4'd9,
    BRANCH    = 4'd10,
    JUMP      = 4'd11,
    JAL       = 4'd12,
    JR        = 4'd13,
    ERROR     = 4'd15
  } state_t;

  state_t        cur, nxt;
  logic [CW-1:0] wait_cnt;
  logic          bus_err_q;
  logic          waiting;
  logic          timeout;
  logic [2:0]    i_op;

  assign waiting = (cur == FETCH) || (cur == MEM_READ) || (cur == MEM_WRITE);
  // The MAX_WAIT-th consecutive stalled cycle is the last one tolerated.
  assign timeout = !mem_ready && (wait_cnt == CW'(MAX_WAIT - 1));

  always_comb begin
    i_op = 3'b000;
    case (opcode)
      OP_ANDI: i_op = 3'b011;
      OP_ORI:  i_op = 3'b100;
      OP_SLTI: i_op = 3'b101;
      default: i_op = 3'b000;
    endcase
  end

  always_comb begin
    nxt = cur;
    case (cur)
      FETCH:     if (mem_ready) nxt = DECODE; else if (timeout) nxt = ERROR;
      DECODE: begin
        case (opcode)
          OP_RTYPE:                         nxt = (funct == FN_JR) ? JR : R_EXEC;
          OP_LW, OP_SW:                     nxt = MEM_ADDR;
          OP_BEQ, OP_BNE:                   nxt = BRANCH;
          OP_J:                             nxt = JUMP;
          OP_JAL:                           nxt = JAL;
          OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: nxt = I_EXEC;
          default:                          nxt = ERROR;
        endcase
      end
      R_EXEC:    nxt = R_WB;
      I_EXEC:    nxt = I_WB;
      MEM_ADDR:  nxt = (opcode == OP_LW) ? MEM_READ : MEM_WRITE;
      MEM_READ:  if (mem_ready) nxt = MEM_WB; else if (timeout) nxt = ERROR;
      MEM_WRITE: if (mem_ready) nxt = FETCH; else if (timeout) nxt = ERROR;
      R_WB, I_WB, MEM_WB, BRANCH, JUMP, JAL, JR: nxt = FETCH;
      default:   nxt = ERROR;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cur       <= FETCH;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      cur       <= nxt;
      bus_err_q <= bus_err_q | (nxt == ERROR);
      if (waiting && !mem_ready) wait_cnt <= wait_cnt + CW'(1);
      else                       wait_cnt <= '0;
    end
  end

  always_comb begin
    PCWrite       = 1'b0;
    PCWriteCond   = 1'b0;
    PCSource      = 2'b00;
    IorD          = 1'b0;
    MemRead       = 1'b0;
    MemWrite      = 1'b0;
    IRWrite       = 1'b0;
    RegDst        = 2'b00;
    MemtoReg      = 1'b0;
    isJAL         = 1'b0;
    RegWrite      = 1'b0;
    ALUSrcA       = 1'b0;
    ALUSrcB       = 2'b00;
    ula_operation = 3'b000;
    if (!reset) begin
      case (cur)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = mem_ready;
          PCWrite = mem_ready;
        end
        DECODE:    ALUSrcB = 2'b11;
        R_EXEC: begin
          ALUSrcA       = 1'b1;
          ula_operation = 3'b010;
        end
        R_WB: begin
          RegDst   = 2'b01;
          RegWrite = 1'b1;
        end
        I_EXEC: begin
          ALUSrcA       = 1'b1;
          ALUSrcB       = 2'b10;
          ula_operation = i_op;
        end
        I_WB: begin
          RegWrite      = 1'b1;
          ula_operation = i_op;
        end
        MEM_ADDR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEM_READ: begin
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        MEM_WB: begin
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        MEM_WRITE: begin
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        BRANCH: begin
          ALUSrcA       = 1'b1;
          ula_operation = 3'b001;
          PCSource      = 2'b01;
          PCWriteCond   = (opcode == OP_BEQ) ? ula_zero_flag : !ula_zero_flag;
        end
        JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        JAL: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
          RegDst   = 2'b10;
          isJAL    = 1'b1;
          RegWrite = 1'b1;
        end
        JR: begin
          PCWrite  = 1'b1;
          PCSource = 2'b11;
        end
        default: ;
      endcase
    end
  end

  assign bus_err = bus_err_q & ~reset;
  assign state   = cur;
endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - randomized trace check of multicycle_control against an instruction-level model
// The model expands each instruction into its expected per-cycle control trace.
module tb_multicycle_control;
  localparam int MAX_WAIT = 16;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [5:0] opcode = '0;
  logic [5:0] funct = '0;
  logic       ula_zero_flag = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic       MemtoReg, isJAL, RegWrite, ALUSrcA, bus_err;
  logic [1:0] PCSource, RegDst, ALUSrcB;
  logic [2:0] ula_operation;
  logic [3:0] state;

  multicycle_control #(.MAX_WAIT(MAX_WAIT)) dut (
    .clock(clock), .reset(reset), .opcode(opcode), .funct(funct),
    .ula_zero_flag(ula_zero_flag), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .PCSource(PCSource),
    .IorD(IorD), .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .isJAL(isJAL), .RegWrite(RegWrite),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ula_operation(ula_operation),
    .bus_err(bus_err), .state(state)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] reg_dst;
    logic       memto_reg;
    logic       is_jal;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] ula_op;
    logic       bus_err;
    logic [3:0] state;
  } ctl_t;

  typedef struct {
    ctl_t        exp;
    logic [23:0] mask;
    logic        rst;
    logic        mr;
    logic        z;
    logic [5:0]  op;
    logic [5:0]  fn;
  } step_t;

  step_t      steps[$];
  logic [5:0] cur_op, cur_fn;
  logic       cur_z;
  int         n_cmp = 0;
  int         n_bad = 0;

  function automatic ctl_t st(input logic [3:0] s);
    ctl_t c = '0;
    c.state = s;
    return c;
  endfunction

  function automatic void push(input ctl_t c, input logic mr);
    step_t s;
    s.exp = c; s.mask = '1; s.rst = 1'b0; s.mr = mr;
    s.z = cur_z; s.op = cur_op; s.fn = cur_fn;
    steps.push_back(s);
  endfunction

  // Reset cycle: every output except state must read 0.
  function automatic void push_reset();
    step_t s;
    s.exp = '0; s.mask = 24'hFFFFF0; s.rst = 1'b1; s.mr = 1'($urandom);
    s.z = 1'($urandom); s.op = 6'($urandom); s.fn = 6'($urandom);
    steps.push_back(s);
  endfunction

  function automatic void push_error(input int n);
    ctl_t c = st(4'd15);
    c.bus_err = 1'b1;
    for (int i = 0; i < n; i++) push(c, 1'($urandom));
    push_reset();
  endfunction

  // Returns 1 when the access ended in ERROR or was cut by reset.
  function automatic bit mem_phase(input ctl_t busy, input ctl_t done, input int stalls, input bit abort);
    for (int i = 0; i < stalls && i < MAX_WAIT; i++) push(busy, 1'b0);
    if (abort) begin
      push_reset();
      return 1'b1;
    end
    if (stalls >= MAX_WAIT) begin
      push_error(3);
      return 1'b1;
    end
    push(done, 1'b1);
    return 1'b0;
  endfunction

  function automatic logic [2:0] imm_op(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b011;
      6'b001101: return 3'b100;
      6'b001010: return 3'b101;
      default:   return 3'b000;
    endcase
  endfunction

  function automatic void gen(input logic [5:0] op, input logic [5:0] fn, input logic z,
                              input int sf, input int sm, input bit abort);
    ctl_t c, d;
    cur_op = op; cur_fn = fn; cur_z = z;
    c = st(4'd0); c.mem_read = 1'b1; c.alu_src_b = 2'b01;
    d = c; d.ir_write = 1'b1; d.pc_write = 1'b1;
    if (mem_phase(c, d, sf, 1'b0)) return;
    c = st(4'd1); c.alu_src_b = 2'b11;
    push(c, 1'($urandom));
    if (op == 6'd0 && fn == 6'b001000) begin
      c = st(4'd13); c.pc_write = 1'b1; c.pc_source = 2'b11; push(c, 1'($urandom));
    end else if (op == 6'd0) begin
      c = st(4'd2); c.alu_src_a = 1'b1; c.ula_op = 3'b010; push(c, 1'($urandom));
      c = st(4'd3); c.reg_dst = 2'b01; c.reg_write = 1'b1; push(c, 1'($urandom));
    end else if (op == 6'b100011 || op == 6'b101011) begin
      c = st(4'd6); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; push(c, 1'($urandom));
      if (op == 6'b100011) begin
        c = st(4'd7); c.iord = 1'b1; c.mem_read = 1'b1;
        if (mem_phase(c, c, sm, abort)) return;
        c = st(4'd8); c.memto_reg = 1'b1; c.reg_write = 1'b1; push(c, 1'($urandom));
      end else begin
        c = st(4'd9); c.iord = 1'b1; c.mem_write = 1'b1;
        void'(mem_phase(c, c, sm, abort));
      end
    end else if (op == 6'b000100 || op == 6'b000101) begin
      c = st(4'd10); c.alu_src_a = 1'b1; c.ula_op = 3'b001; c.pc_source = 2'b01;
      c.pc_write_cond = (op == 6'b000100) ? z : !z;
      push(c, 1'($urandom));
    end else if (op == 6'b000010 || op == 6'b000011) begin
      c = st(op == 6'b000010 ? 4'd11 : 4'd12); c.pc_write = 1'b1; c.pc_source = 2'b10;
      if (op == 6'b000011) begin
        c.reg_dst = 2'b10; c.is_jal = 1'b1; c.reg_write = 1'b1;
      end
      push(c, 1'($urandom));
    end else if (op == 6'b001000 || op == 6'b001100 || op == 6'b001101 || op == 6'b001010) begin
      c = st(4'd4); c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.ula_op = imm_op(op); push(c, 1'($urandom));
      c = st(4'd5); c.reg_write = 1'b1; c.ula_op = imm_op(op); push(c, 1'($urandom));
    end else begin
      push_error(3);
    end
  endfunction

  function automatic void check_val(input string name, input int got, input int want);
    n_cmp++;
    if (got != want) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endfunction

  function automatic int pick_stall();
    int r = $urandom_range(0, 99);
    if (r < 70) return 0;
    if (r < 92) return $urandom_range(1, 4);
    if (r < 96) return MAX_WAIT - 1;
    return MAX_WAIT;
  endfunction

  initial begin
    int b;
    logic [5:0] ops [13];
    logic [23:0] act, lit;
    ops = '{6'h00, 6'h00, 6'h23, 6'h2b, 6'h04, 6'h05, 6'h02, 6'h03, 6'h08, 6'h0c, 6'h0d, 6'h0a, 6'h3f};
    cur_op = '0; cur_fn = '0; cur_z = 1'b0;
    push_reset();

    b = steps.size(); gen(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);
    check_val("add_len", steps.size() - b, 4);
    lit = steps[b+3].exp; check_val("r_wb_vec", int'(lit), 24'h004803);
    b = steps.size(); gen(6'h23, 6'h00, 1'b0, 0, 3, 1'b0);
    check_val("lw_stall3_len", steps.size() - b, 8);
    b = steps.size(); gen(6'h04, 6'h11, 1'b1, 0, 0, 1'b0);
    check_val("beq_len", steps.size() - b, 3);
    lit = steps[b+2].exp; check_val("beq_z1_vec", int'(lit), 24'h50042A);
    b = steps.size(); gen(6'h05, 6'h11, 1'b1, 0, 0, 1'b0);
    lit = steps[b+2].exp; check_val("bne_z1_vec", int'(lit), 24'h10042A);
    b = steps.size(); gen(6'h03, 6'h00, 1'b0, 0, 0, 1'b0);
    lit = steps[b+2].exp; check_val("jal_vec", int'(lit), 24'hA0980C);
    b = steps.size(); gen(6'h00, 6'h08, 1'b0, 0, 0, 1'b0);
    check_val("jr_len", steps.size() - b, 3);
    b = steps.size(); gen(6'h2b, 6'h00, 1'b0, 0, 0, 1'b0);
    check_val("sw_len", steps.size() - b, 4);
    b = steps.size(); gen(6'h0d, 6'h00, 1'b0, 0, 0, 1'b0);
    check_val("ori_len", steps.size() - b, 4);
    b = steps.size(); gen(6'h00, 6'h20, 1'b0, MAX_WAIT, 0, 1'b0);
    check_val("fetch_timeout_len", steps.size() - b, MAX_WAIT + 4);
    b = steps.size(); gen(6'h3f, 6'h00, 1'b0, 0, 0, 1'b0);
    check_val("illegal_len", steps.size() - b, 6);
    b = steps.size(); gen(6'h00, 6'h22, 1'b0, MAX_WAIT - 1, 0, 1'b0);
    check_val("fetch_last_chance_len", steps.size() - b, MAX_WAIT + 3);
    gen(6'h23, 6'h00, 1'b0, 0, MAX_WAIT - 1, 1'b0);
    gen(6'h2b, 6'h00, 1'b0, 0, MAX_WAIT, 1'b0);
    gen(6'h2b, 6'h00, 1'b0, 1, 2, 1'b1);
    gen(6'h00, 6'h20, 1'b0, 0, 0, 1'b0);

    for (int k = 0; k < 160; k++) begin
      logic [5:0] op, fn;
      bit ab;
      op = ops[$urandom_range(0, 12)];
      if (op == 6'h3f) op = 6'($urandom);
      fn = 6'($urandom);
      if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'b001000;
      ab = ($urandom_range(0, 29) == 0);
      gen(op, fn, 1'($urandom), pick_stall(), ab ? $urandom_range(0, 4) : pick_stall(), ab);
    end

    foreach (steps[i]) begin
      @(posedge clock);
      #1;
      reset = steps[i].rst;
      mem_ready = steps[i].mr;
      opcode = steps[i].op;
      funct = steps[i].fn;
      ula_zero_flag = steps[i].z;
      @(negedge clock);
      act = {PCWrite, PCWriteCond, PCSource, IorD, MemRead, MemWrite, IRWrite, RegDst,
             MemtoReg, isJAL, RegWrite, ALUSrcA, ALUSrcB, ula_operation, bus_err, state};
      n_cmp++;
      if ((act & steps[i].mask) !== (24'(steps[i].exp) & steps[i].mask)) begin
        n_bad++;
        $display("FAIL step %0d ctl(state %0d, rst %0b): got %h want %h mask %h",
                 i, steps[i].exp.state, steps[i].rst, act, 24'(steps[i].exp), steps[i].mask);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
